// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// Emulates the serial side of a simple SPI ADC. A sample is placed in a
// one-entry holding register through a valid/ready handshake. When the master
// pulls adc_cs low, the block serves one frame on adc_so: LEAD_ZEROS zero bits
// followed by the DATA_WIDTH sample bits, MSB first. Each adc_clk falling edge
// advances the frame by one bit. If no fresh sample is held when a frame
// starts, the last served sample is repeated and underrun pulses.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         synchronous, active-high reset
//   sample_data   sample to be served (DATA_WIDTH bits)
//   sample_valid  sample_data is valid
//   sample_ready  holding register is empty
//   adc_cs        chip select from master, active low, asynchronous to clk
//   adc_clk       serial clock from master, asynchronous to clk
//   adc_so        serial data to master (registered)
//   frame_done    one-cycle pulse when a full frame has been sent
//   frame_abort   one-cycle pulse when CS rises mid-frame
//   underrun      one-cycle pulse when a frame starts with no new sample
// -----------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int LEAD_ZEROS = 4,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  adc_cs,
  input  logic                  adc_clk,
  output logic                  adc_so,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  underrun
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_t;

  // Synchronizers: stage 1, stage 2, and a third copy used for edge detection.
  logic cs_sync1_r, cs_sync2_r, cs_sync3_r;
  logic sclk_sync1_r, sclk_sync2_r, sclk_sync3_r;

  // Arming: after reset, a frame may only start from a CS fall that follows
  // a genuinely observed CS-high level. Without this, a reset taken while CS
  // is held low would look like a fresh falling edge once the synchronizer
  // (preset to 1) flushes.
  logic [1:0] settle_cnt_r;
  logic       armed_r;

  logic cs_fall_s;
  logic cs_rise_s;
  logic sclk_fall_s;

  state_t                  state_r;
  logic                    hold_valid_r;
  logic [DATA_WIDTH-1:0]   hold_data_r;
  logic [DATA_WIDTH-1:0]   last_data_r;
  logic [FRAME_BITS-1:0]   shifter_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic                    adc_so_r;
  logic                    frame_done_r;
  logic                    frame_abort_r;
  logic                    underrun_r;
  logic [FRAME_BITS-1:0]   load_word_s;
  logic [CNT_W-1:0]        bit_cnt_inc_s;

  // Double-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync1_r   <= 1'b1;
      cs_sync2_r   <= 1'b1;
      cs_sync3_r   <= 1'b1;
      sclk_sync1_r <= 1'b1;
      sclk_sync2_r <= 1'b1;
      sclk_sync3_r <= 1'b1;
    end else begin
      cs_sync1_r   <= adc_cs;
      cs_sync2_r   <= cs_sync1_r;
      cs_sync3_r   <= cs_sync2_r;
      sclk_sync1_r <= adc_clk;
      sclk_sync2_r <= sclk_sync1_r;
      sclk_sync3_r <= sclk_sync2_r;
    end
  end

  // Arm frame starts once the synchronizer has flushed and CS is seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt_r <= 2'd0;
      armed_r      <= 1'b0;
    end else begin
      if (settle_cnt_r != 2'd3) begin
        settle_cnt_r <= settle_cnt_r + 2'd1;
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      if ((settle_cnt_r == 2'd3) && cs_sync2_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign cs_fall_s   = cs_sync3_r & ~cs_sync2_r;
  assign cs_rise_s   = ~cs_sync3_r & cs_sync2_r;
  assign sclk_fall_s = sclk_sync3_r & ~sclk_sync2_r;

  assign bit_cnt_inc_s = bit_cnt_r + CNT_ONE;

  // Frame word: fresh sample if one is held, otherwise repeat the last one.
  always_comb begin
    load_word_s = {FRAME_BITS{1'b0}};
    if (hold_valid_r) begin
      load_word_s = {{LEAD_ZEROS{1'b0}}, hold_data_r};
    end else begin
      load_word_s = {{LEAD_ZEROS{1'b0}}, last_data_r};
    end
  end

  // Holding register, frame state machine, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      hold_valid_r  <= 1'b0;
      hold_data_r   <= {DATA_WIDTH{1'b0}};
      last_data_r   <= {DATA_WIDTH{1'b0}};
      shifter_r     <= {FRAME_BITS{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      adc_so_r      <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      underrun_r    <= 1'b0;

      // Accept only into an empty holding register; the frame-start clear
      // below only fires when it is full, so the two never collide.
      if (sample_valid && !hold_valid_r) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= sample_data;
      end else begin
        hold_data_r  <= hold_data_r;
      end

      case (state_r)
        ST_IDLE: begin
          adc_so_r <= 1'b0;
          if (cs_fall_s && armed_r) begin
            state_r   <= ST_SHIFT;
            shifter_r <= load_word_s;
            bit_cnt_r <= {CNT_W{1'b0}};
            adc_so_r  <= load_word_s[FRAME_BITS-1];
            if (hold_valid_r) begin
              last_data_r  <= hold_data_r;
              hold_valid_r <= 1'b0;
            end else begin
              underrun_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (cs_rise_s) begin
            // Master gave up mid-frame; the sample stays only in last_data.
            frame_abort_r <= 1'b1;
            adc_so_r      <= 1'b0;
            state_r       <= ST_IDLE;
          end else if (sclk_fall_s) begin
            shifter_r <= {shifter_r[FRAME_BITS-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_inc_s;
            if (bit_cnt_inc_s == CNT_LAST) begin
              frame_done_r <= 1'b1;
              adc_so_r     <= 1'b0;
              state_r      <= ST_WAIT_CS;
            end else begin
              adc_so_r <= shifter_r[FRAME_BITS-2];
            end
          end else begin
            adc_so_r <= shifter_r[FRAME_BITS-1];
          end
        end

        ST_WAIT_CS: begin
          adc_so_r <= 1'b0;
          if (cs_rise_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_CS;
          end
        end

        default: begin
          adc_so_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = ~hold_valid_r;
  assign adc_so       = adc_so_r;
  assign frame_done   = frame_done_r;
  assign frame_abort  = frame_abort_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_responder
//
// Directed bench for adc_spi_responder. Stimulus is applied on the falling
// edge of clk; DUT outputs are sampled on the falling edge too. Pulse outputs
// are tallied by a free-running monitor, and tasks compare deltas of those
// tallies against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        adc_cs;
  logic        adc_clk;
  logic        adc_so;
  logic        frame_done;
  logic        frame_abort;
  logic        underrun;

  int checks   = 0;
  int failures = 0;

  int done_total  = 0;
  int abort_total = 0;
  int under_total = 0;
  int ready_total = 0;

  adc_spi_responder #(
    .LEAD_ZEROS(4),
    .DATA_WIDTH(12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .adc_cs      (adc_cs),
    .adc_clk     (adc_clk),
    .adc_so      (adc_so),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .underrun    (underrun)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Tally pulse outputs and cycles with sample_ready high.
  always @(negedge clk) begin
    if (frame_done)   done_total  <= done_total + 1;
    if (frame_abort)  abort_total <= abort_total + 1;
    if (underrun)     under_total <= under_total + 1;
    if (sample_ready) ready_total <= ready_total + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    adc_cs       = 1'b1;
    adc_clk      = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 12'h000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic load_sample(input logic [11:0] d);
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drive CS low, then nfalls SCLK periods of 400 ns. adc_so is captured just
  // before each falling edge; bits beyond 16 and the post-loop value are ORed
  // into tail_so. CS is optionally raised at the end.
  task automatic run_frame(input int nfalls, input bit raise_cs,
                           output logic [15:0] bits, output logic tail_so);
    bits    = 16'h0000;
    tail_so = 1'b0;
    @(negedge clk);
    adc_cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      if (i < 16) bits[15-i] = adc_so;
      else        tail_so    = tail_so | adc_so;
      adc_clk = 1'b0;
      repeat (10) @(negedge clk);
      adc_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    tail_so = tail_so | adc_so;
    if (raise_cs) begin
      adc_cs = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (adc_so !== 1'b0) begin
      failures++; $display("FAIL reset_adc_so got=%b exp=0", adc_so);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++; $display("FAIL reset_sample_ready got=%b exp=1", sample_ready);
    end
    checks++;
    if ({frame_done, frame_abort, underrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got=%b%b%b exp=000", frame_done, frame_abort, underrun);
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] bits;
    logic        tail;
    int d0, u0, a0;
    do_reset();
    load_sample(12'hA5C);
    checks++;
    if (sample_ready !== 1'b0) begin
      failures++; $display("FAIL basic_ready_after_load got=%b exp=0", sample_ready);
    end
    d0 = done_total; u0 = under_total; a0 = abort_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0A5C) begin
      failures++; $display("FAIL basic_bits got=%h exp=0a5c", bits);
    end
    checks++;
    if (done_total - d0 !== 1) begin
      failures++; $display("FAIL basic_done_count got=%0d exp=1", done_total - d0);
    end
    checks++;
    if ((under_total - u0 !== 0) || (abort_total - a0 !== 0)) begin
      failures++;
      $display("FAIL basic_no_under_abort got under=%0d abort=%0d exp=0,0",
               under_total - u0, abort_total - a0);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready_after_frame got=%b exp=1", sample_ready);
    end
    checks++;
    if (tail !== 1'b0) begin
      failures++; $display("FAIL basic_so_after_frame got=%b exp=0", tail);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] bits;
    logic        tail;
    int u0;
    do_reset();
    u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0000) begin
      failures++; $display("FAIL under_empty_bits got=%h exp=0000", bits);
    end
    checks++;
    if (under_total - u0 !== 1) begin
      failures++; $display("FAIL under_empty_pulse got=%0d exp=1", under_total - u0);
    end
    load_sample(12'hFFF);
    u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0FFF || under_total - u0 !== 0) begin
      failures++;
      $display("FAIL under_fresh got bits=%h under=%0d exp=0fff,0", bits, under_total - u0);
    end
    u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0FFF) begin
      failures++; $display("FAIL under_repeat_bits got=%h exp=0fff", bits);
    end
    checks++;
    if (under_total - u0 !== 1) begin
      failures++; $display("FAIL under_repeat_pulse got=%0d exp=1", under_total - u0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] bits;
    logic        tail;
    int a0, d0, u0;
    load_sample(12'h123);
    a0 = abort_total; d0 = done_total;
    run_frame(7, 1'b1, bits, tail);
    checks++;
    if (abort_total - a0 !== 1 || done_total - d0 !== 0) begin
      failures++;
      $display("FAIL abort_pulses got abort=%0d done=%0d exp=1,0",
               abort_total - a0, done_total - d0);
    end
    checks++;
    if (adc_so !== 1'b0) begin
      failures++; $display("FAIL abort_so got=%b exp=0", adc_so);
    end
    u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0123) begin
      failures++; $display("FAIL abort_reserve_bits got=%h exp=0123", bits);
    end
    checks++;
    if (under_total - u0 !== 1) begin
      failures++; $display("FAIL abort_reserve_under got=%0d exp=1", under_total - u0);
    end
  endtask

  task automatic test_hold_block();
    logic [15:0] bits;
    logic        tail;
    int r0, u0;
    load_sample(12'h001);
    @(negedge clk);
    sample_data  = 12'h7FF;
    sample_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sample_ready !== 1'b0) begin
      failures++; $display("FAIL hold_ready_blocked got=%b exp=0", sample_ready);
    end
    r0 = ready_total;
    run_frame(16, 1'b1, bits, tail);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bits !== 16'h0001) begin
      failures++; $display("FAIL hold_bits got=%h exp=0001", bits);
    end
    checks++;
    if (ready_total - r0 !== 1) begin
      failures++; $display("FAIL hold_ready_window got=%0d exp=1", ready_total - r0);
    end
    u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h07FF || under_total - u0 !== 0) begin
      failures++;
      $display("FAIL hold_next_frame got bits=%h under=%0d exp=07ff,0", bits, under_total - u0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bits;
    logic        tail;
    logic        any_high;
    int d0, u0, a0;
    load_sample(12'h3C3);
    @(negedge clk);
    adc_cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      adc_clk = 1'b0;
      repeat (10) @(negedge clk);
      adc_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = done_total; u0 = under_total; a0 = abort_total;
    repeat (2) @(negedge clk);
    checks++;
    if (adc_so !== 1'b0) begin
      failures++; $display("FAIL rstmid_so got=%b exp=0", adc_so);
    end
    any_high = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc_clk = 1'b0;
      repeat (10) @(negedge clk);
      any_high = any_high | adc_so;
      adc_clk = 1'b1;
      repeat (10) @(negedge clk);
      any_high = any_high | adc_so;
    end
    checks++;
    if (any_high !== 1'b0) begin
      failures++; $display("FAIL rstmid_quiet_so got=%b exp=0", any_high);
    end
    checks++;
    if (done_total - d0 !== 0 || under_total - u0 !== 0 || abort_total - a0 !== 0) begin
      failures++;
      $display("FAIL rstmid_no_frame got done=%0d under=%0d abort=%0d exp=0,0,0",
               done_total - d0, under_total - u0, abort_total - a0);
    end
    adc_cs = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_total; u0 = under_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h0000 || done_total - d0 !== 1 || under_total - u0 !== 1) begin
      failures++;
      $display("FAIL rstmid_fresh got bits=%h done=%0d under=%0d exp=0000,1,1",
               bits, done_total - d0, under_total - u0);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] bits;
    logic        tail;
    int d0;
    load_sample(12'h5A5);
    d0 = done_total;
    run_frame(18, 1'b0, bits, tail);
    checks++;
    if (bits !== 16'h05A5) begin
      failures++; $display("FAIL over_bits got=%h exp=05a5", bits);
    end
    checks++;
    if (tail !== 1'b0) begin
      failures++; $display("FAIL over_tail_so got=%b exp=0", tail);
    end
    checks++;
    if (done_total - d0 !== 1) begin
      failures++; $display("FAIL over_done_count got=%0d exp=1", done_total - d0);
    end
    adc_cs = 1'b1;
    repeat (10) @(negedge clk);
    load_sample(12'h0F0);
    d0 = done_total;
    run_frame(16, 1'b1, bits, tail);
    checks++;
    if (bits !== 16'h00F0 || done_total - d0 !== 1) begin
      failures++;
      $display("FAIL over_next_frame got bits=%h done=%0d exp=00f0,1", bits, done_total - d0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    adc_cs       = 1'b1;
    adc_clk      = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 12'h000;
    test_reset();
    test_basic_frame();
    test_underrun();
    test_abort();
    test_hold_block();
    test_reset_mid();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
